// File: rtl/led_sequencer.sv
// led_sequencer: Avalon-MM slave stepping a small pattern table onto the LED bank,
// with looping, manual override and a done interrupt. Define LED_SEQ_PWM_EN for PWM dimming.
module led_sequencer #(
    parameter int WIDTH    = 26,
    parameter int DEPTH    = 8,
    parameter int PERIOD_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);
    localparam int         IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH4 = 4'(DEPTH);

    typedef struct packed {
        logic irq_en;
        logic manual;
        logic loop;
        logic run;
    } ctrl_t;

    typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

    state_t                      state;
    ctrl_t                       ctrl;
    logic                        done_flag;
    logic [PERIOD_W-1:0]         period;
    logic [PERIOD_W-1:0]         cnt;
    logic [PERIOD_W-1:0]         eff_period;
    logic [2:0]                  length;
    logic [3:0]                  eff_len;
    logic [3:0]                  last4;
    logic [WIDTH-1:0]            manual_val;
    logic [WIDTH-1:0]            seq_out;
    logic [WIDTH-1:0]            sel_val;
    logic [DEPTH-1:0][WIDTH-1:0] pattern;
    logic [IW-1:0]               idx;
    logic [IW-1:0]               nxt_idx;
    logic [IW-1:0]               last_idx;
    logic [2:0]                  idx3;
    logic                        wr;
    logic                        ctrl_wr;
    logic                        status_wr;
    logic                        pat_sel;
    logic                        start;
    logic                        busy;
    logic                        unused;

    assign wr        = chipselect && !write_n;
    assign ctrl_wr   = wr && (address == 4'd0);
    assign status_wr = wr && (address == 4'd1);
    assign pat_sel   = address[3] && ({1'b0, address[2:0]} < DEPTH4);
    assign start     = ctrl_wr && writedata[0] && !ctrl.run;
    assign busy      = (state == STEP);
    assign irq       = done_flag && ctrl.irq_en;
    assign idx3      = 3'(idx);
    assign nxt_idx   = idx + IW'(1);
    assign unused    = ^writedata;

    assign eff_period = (period == '0) ? PERIOD_W'(1) : period;
    assign eff_len    = ((length == 3'd0) || ({1'b0, length} > DEPTH4)) ? DEPTH4 : {1'b0, length};
    assign last4      = eff_len - 4'd1;
    assign last_idx   = last4[IW-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period     <= '0;
            length     <= '0;
            manual_val <= '0;
            pattern    <= '0;
        end else if (wr) begin
            if (address == 4'd2) period     <= writedata[PERIOD_W-1:0];
            if (address == 4'd3) length     <= writedata[2:0];
            if (address == 4'd4) manual_val <= writedata[WIDTH-1:0];
            if (pat_sel)         pattern[address[IW-1:0]] <= writedata[WIDTH-1:0];
        end
    end

    // Later assignments win: hardware DONE set overrides a same-cycle software clear,
    // and RUN auto-clear overrides a same-cycle CTRL write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ctrl      <= '0;
            done_flag <= 1'b0;
            idx       <= '0;
            cnt       <= '0;
            seq_out   <= '0;
        end else begin
            if (ctrl_wr)                  ctrl      <= ctrl_t'(writedata[3:0]);
            if (status_wr && writedata[1]) done_flag <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= STEP;
                        idx       <= '0;
                        cnt       <= eff_period;
                        seq_out   <= pattern[0];
                        done_flag <= 1'b0;
                    end
                end
                STEP: begin
                    if (ctrl_wr && !writedata[0]) begin
                        state <= IDLE;
                    end else if (cnt <= PERIOD_W'(1)) begin
                        cnt <= eff_period;
                        if (idx >= last_idx) begin
                            if (ctrl.loop) begin
                                idx     <= '0;
                                seq_out <= pattern[0];
                            end else begin
                                state     <= DONE;
                                done_flag <= 1'b1;
                                ctrl.run  <= 1'b0;
                            end
                        end else begin
                            idx     <= nxt_idx;
                            seq_out <= pattern[nxt_idx];
                        end
                    end else begin
                        cnt <= cnt - PERIOD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Both sources are registers, so the override shows one cycle after its write.
    assign sel_val = ctrl.manual ? manual_val : seq_out;

`ifdef LED_SEQ_PWM_EN
    logic [7:0]       duty;
    logic [7:0]       pwm_cnt;
    logic [WIDTH-1:0] pwm_q;
    logic             pwm_on;

    assign pwm_on = (duty == 8'hFF) || (pwm_cnt < duty);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty    <= 8'hFF;
            pwm_cnt <= '0;
            pwm_q   <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (wr && (address == 4'd5)) duty <= writedata[7:0];
            pwm_q <= pwm_on ? sel_val : '0;
        end
    end

    assign out_port = pwm_q;
`else
    assign out_port = sel_val;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            4'd0: readdata = 32'(ctrl);
            4'd1: readdata = {25'd0, idx3, 2'b00, done_flag, busy};
            4'd2: readdata = 32'(period);
            4'd3: readdata = 32'(length);
            4'd4: readdata = 32'(manual_val);
`ifdef LED_SEQ_PWM_EN
            4'd5: readdata = 32'(duty);
`endif
            default: if (pat_sel) readdata = 32'(pattern[address[IW-1:0]]);
        endcase
    end
endmodule

// File: tb/tb_led_sequencer.sv
// Directed self-checking bench for led_sequencer (default build; PWM scenario when LED_SEQ_PWM_EN is set).
module tb_led_sequencer;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [25:0] out_port;
    logic        irq;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    led_sequencer dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .out_port(out_port), .irq(irq)
    );

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (out_port !== 26'd0) begin failures++; $display("FAIL reset_out got=%h exp=0", out_port); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        rd(4'd1, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%h exp=0", d); end
        rd(4'd0, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
`ifdef LED_SEQ_PWM_EN
        rd(4'd5, d);
        checks++; if (d !== 32'hFF) begin failures++; $display("FAIL reset_duty got=%h exp=ff", d); end
`endif
    endtask

    task automatic test_oneshot;
        logic [31:0] d;
        logic [25:0] exp;
        wr(4'd8, 32'd1); wr(4'd9, 32'd2); wr(4'd10, 32'd4);
        wr(4'd3, 32'd3); wr(4'd2, 32'd5); wr(4'd0, 32'h9);
        for (int k = 0; k < 15; k++) begin
            exp = 26'd1 << (k / 5);
            checks++; if (out_port !== exp) begin failures++; $display("FAIL oneshot_out k=%0d got=%h exp=%h", k, out_port, exp); end
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_early k=%0d got=%b exp=0", k, irq); end
            @(negedge clk);
        end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq got=%b exp=1", irq); end
        checks++; if (out_port !== 26'd4) begin failures++; $display("FAIL oneshot_hold got=%h exp=4", out_port); end
        rd(4'd1, d);
        checks++; if (d !== 32'h22) begin failures++; $display("FAIL oneshot_status got=%h exp=22", d); end
        rd(4'd0, d);
        checks++; if (d !== 32'h8) begin failures++; $display("FAIL oneshot_run_clear got=%h exp=8", d); end
        wr(4'd1, 32'h2);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_clear got=%b exp=0", irq); end
        rd(4'd1, d);
        checks++; if (d !== 32'h20) begin failures++; $display("FAIL oneshot_done_clear got=%h exp=20", d); end
    endtask

    task automatic test_loop;
        logic [31:0] d;
        logic [25:0] exp;
        wr(4'd0, 32'hB);
        for (int k = 0; k < 20; k++) begin
            exp = 26'd1 << ((k / 5) % 3);
            checks++; if (out_port !== exp) begin failures++; $display("FAIL loop_out k=%0d got=%h exp=%h", k, out_port, exp); end
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL loop_irq k=%0d got=%b exp=0", k, irq); end
            @(negedge clk);
        end
        wr(4'd0, 32'h0);
        rd(4'd1, d);
        checks++; if (d !== 32'h10) begin failures++; $display("FAIL loop_stop_status got=%h exp=10", d); end
        checks++; if (out_port !== 26'd2) begin failures++; $display("FAIL loop_stop_out got=%h exp=2", out_port); end
        repeat (10) @(negedge clk);
        checks++; if (out_port !== 26'd2) begin failures++; $display("FAIL loop_frozen got=%h exp=2", out_port); end
        rd(4'd1, d);
        checks++; if (d !== 32'h10) begin failures++; $display("FAIL loop_frozen_status got=%h exp=10", d); end
    endtask

    task automatic test_manual;
        logic [31:0] d;
        wr(4'd0, 32'h3);
        repeat (2) @(negedge clk);
        wr(4'd4, 32'h3FFFFFF);
        wr(4'd0, 32'h7);
        checks++; if (out_port !== 26'h3FFFFFF) begin failures++; $display("FAIL manual_on got=%h exp=3ffffff", out_port); end
        repeat (8) @(negedge clk);
        checks++; if (out_port !== 26'h3FFFFFF) begin failures++; $display("FAIL manual_hold got=%h exp=3ffffff", out_port); end
        rd(4'd1, d);
        checks++; if (d !== 32'h21) begin failures++; $display("FAIL manual_underneath got=%h exp=21", d); end
        wr(4'd0, 32'h3);
        checks++; if (out_port !== 26'd4) begin failures++; $display("FAIL manual_off got=%h exp=4", out_port); end
        repeat (2) @(negedge clk);
        checks++; if (out_port !== 26'd1) begin failures++; $display("FAIL manual_wrap got=%h exp=1", out_port); end
        wr(4'd0, 32'h0);
    endtask

    task automatic test_fast;
        logic [31:0] d;
        logic [25:0] exp;
        for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'h100 + 32'(i) * 32'h11);
        wr(4'd2, 32'd0); wr(4'd3, 32'd0); wr(4'd0, 32'h9);
        for (int k = 0; k < 8; k++) begin
            exp = 26'h100 + 26'(k) * 26'h11;
            checks++; if (out_port !== exp) begin failures++; $display("FAIL fast_out k=%0d got=%h exp=%h", k, out_port, exp); end
            @(negedge clk);
        end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fast_irq got=%b exp=1", irq); end
        checks++; if (out_port !== 26'h177) begin failures++; $display("FAIL fast_hold got=%h exp=177", out_port); end
        rd(4'd1, d);
        checks++; if (d !== 32'h72) begin failures++; $display("FAIL fast_status got=%h exp=72", d); end
        wr(4'd1, 32'h2);
    endtask

    task automatic test_regs;
        logic [31:0] d;
        wr(4'd2, 32'hFF123456); rd(4'd2, d);
        checks++; if (d !== 32'h123456) begin failures++; $display("FAIL reg_period got=%h exp=123456", d); end
        wr(4'd3, 32'hF); rd(4'd3, d);
        checks++; if (d !== 32'h7) begin failures++; $display("FAIL reg_length got=%h exp=7", d); end
        wr(4'd5, 32'hAB); rd(4'd5, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL reg_unmapped got=%h exp=0", d); end
        rd(4'd12, d);
        checks++; if (d !== 32'h144) begin failures++; $display("FAIL reg_pattern4 got=%h exp=144", d); end
        wr(4'd15, 32'hFFFFFFFF); rd(4'd15, d);
        checks++; if (d !== 32'h3FFFFFF) begin failures++; $display("FAIL reg_pattern_mask got=%h exp=3ffffff", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        wr(4'd2, 32'd5); wr(4'd3, 32'd0); wr(4'd0, 32'h9);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (out_port !== 26'd0) begin failures++; $display("FAIL rstmid_out got=%h exp=0", out_port); end
        rd(4'd1, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rstmid_status got=%h exp=0", d); end
        rd(4'd2, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rstmid_period got=%h exp=0", d); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

`ifdef LED_SEQ_PWM_EN
    task automatic test_pwm;
        int cnt;
        logic [7:0] duties [3];
        int exps [3];
        duties[0] = 8'd64; duties[1] = 8'd0; duties[2] = 8'd255;
        exps[0] = 64; exps[1] = 0; exps[2] = 256;
        wr(4'd4, 32'd1); wr(4'd0, 32'h4);
        for (int t = 0; t < 3; t++) begin
            wr(4'd5, 32'(duties[t]));
            repeat (3) @(negedge clk);
            cnt = 0;
            for (int c = 0; c < 256; c++) begin
                cnt += int'(out_port[0]);
                @(negedge clk);
            end
            checks++; if (cnt !== exps[t]) begin failures++; $display("FAIL pwm_duty%0d got=%0d exp=%0d", duties[t], cnt, exps[t]); end
        end
    endtask
`endif

    initial begin
        test_reset;
`ifdef LED_SEQ_PWM_EN
        test_pwm;
`else
        test_oneshot;
        test_loop;
        test_manual;
        test_fast;
        test_regs;
        test_reset_mid;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
